// File: rtl/flip_metric_sel_pkg.sv
// Shared types and widths for the flip-metric selector (LLR store consumer).
package flip_metric_sel_pkg;
  localparam int LLR_W  = 7;
  localparam int POS_W  = 10;
  localparam int MET_W  = 9;
  localparam int MAG_W  = 7;
  localparam int NUM_W  = 3;
  localparam int NPOS   = 6;
  localparam int STAGES = 3;
  localparam logic [POS_W-1:0] CW_LEN  = 10'd1023;
  localparam logic [MET_W-1:0] MET_MAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  typedef struct packed {
    logic [NUM_W-1:0]            num;
    logic [NPOS-1:0][POS_W-1:0]  pos;
  } cand_t;

  function automatic logic [NUM_W-1:0] clamp_num(input logic [NUM_W-1:0] n);
    return (n > NUM_W'(NPOS)) ? NUM_W'(NPOS) : n;
  endfunction
endpackage

// File: rtl/flip_metric_sel_llr_abs_sum.sv
// Masked |LLR| sum over one candidate's positions; purely combinational.
module llr_abs_sum
  import flip_metric_sel_pkg::*;
(
  input  cand_t                      cand,
  input  logic [NPOS-1:0][LLR_W-1:0] llr,
  output logic [MET_W-1:0]           sum
);
  logic [NPOS-1:0][MAG_W-1:0] mag;

  for (genvar k = 0; k < NPOS; k++) begin : g_lane
    logic [MAG_W-1:0] abs_v;
    logic             use_lane;
    // -64 negates to 7'b1000000, which reads as 64 unsigned
    assign abs_v    = llr[k][LLR_W-1] ? (~llr[k] + 1'b1) : llr[k];
    assign use_lane = (NUM_W'(k) < cand.num) && (cand.pos[k] < CW_LEN);
    assign mag[k]   = use_lane ? abs_v : '0;
  end

  always_comb begin
    sum = '0;
    for (int k = 0; k < NPOS; k++) sum = sum + MET_W'(mag[k]);
  end
endmodule

// File: rtl/flip_metric_sel.sv
// Scores Chase candidates by sum |LLR| and tracks the per-batch minimum.
// Optional FLIP_METRIC_FAIL_EN adds i_cand_fail: failed candidates never win.
module flip_metric_sel
  import flip_metric_sel_pkg::*;
#(
  parameter  int MAX_CAND = 16,
  localparam int CIDX_W   = $clog2(MAX_CAND)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_cand_valid,
  output logic              o_cand_ready,
  input  logic              i_cand_last,
  input  logic [NUM_W-1:0]  i_cand_num,
  input  logic [POS_W-1:0]  i_cand_pos0,
  input  logic [POS_W-1:0]  i_cand_pos1,
  input  logic [POS_W-1:0]  i_cand_pos2,
  input  logic [POS_W-1:0]  i_cand_pos3,
  input  logic [POS_W-1:0]  i_cand_pos4,
  input  logic [POS_W-1:0]  i_cand_pos5,
  output logic [POS_W-1:0]  o_llr_pos0,
  output logic [POS_W-1:0]  o_llr_pos1,
  output logic [POS_W-1:0]  o_llr_pos2,
  output logic [POS_W-1:0]  o_llr_pos3,
  output logic [POS_W-1:0]  o_llr_pos4,
  output logic [POS_W-1:0]  o_llr_pos5,
  input  logic [LLR_W-1:0]  i_llr0,
  input  logic [LLR_W-1:0]  i_llr1,
  input  logic [LLR_W-1:0]  i_llr2,
  input  logic [LLR_W-1:0]  i_llr3,
  input  logic [LLR_W-1:0]  i_llr4,
  input  logic [LLR_W-1:0]  i_llr5,
  output logic              o_done,
  output logic              o_best_valid,
  output logic [CIDX_W-1:0] o_best_idx,
  output logic [MET_W-1:0]  o_best_metric,
  output logic [NUM_W-1:0]  o_best_num,
  output logic [POS_W-1:0]  o_best_pos0,
  output logic [POS_W-1:0]  o_best_pos1,
  output logic [POS_W-1:0]  o_best_pos2,
  output logic [POS_W-1:0]  o_best_pos3,
  output logic [POS_W-1:0]  o_best_pos4,
  output logic [POS_W-1:0]  o_best_pos5,
  output logic              o_overflow
`ifdef FLIP_METRIC_FAIL_EN
  ,
  input  logic              i_cand_fail
`endif
);
  localparam logic [CIDX_W:0] CMAX = (CIDX_W+1)'(MAX_CAND);

  state_t                     state_q, state_d;
  logic [1:0]                 flush_q;
  logic [CIDX_W:0]            cnt_q;
  logic                       hs, score, cnt_full, upd, fail_in, started_q;
  logic [STAGES:1]            vld_pipe;
  cand_t [STAGES:1]           cand_pipe;
  logic [STAGES:1][CIDX_W-1:0] idx_pipe;
  logic [STAGES:1]            fail_pipe;
  cand_t                      cand_in;
  logic [NPOS-1:0][LLR_W-1:0] llr_q;
  logic [MET_W-1:0]           sum_s2, sum_q;
  logic [MET_W-1:0]           best_met_q;
  logic                       best_valid_q;
  logic [CIDX_W-1:0]          best_idx_q;
  cand_t                      best_cand_q;
  logic                       ovf_q;

`ifdef FLIP_METRIC_FAIL_EN
  assign fail_in = i_cand_fail;
`else
  assign fail_in = 1'b0;
`endif

  assign cand_in.num = clamp_num(i_cand_num);
  assign cand_in.pos = {i_cand_pos5, i_cand_pos4, i_cand_pos3,
                        i_cand_pos2, i_cand_pos1, i_cand_pos0};

  // i_start wins over a same-cycle handshake
  assign hs       = i_cand_valid && o_cand_ready && !i_start;
  assign cnt_full = (cnt_q == CMAX);
  assign score    = hs && !cnt_full;
  assign upd      = vld_pipe[STAGES] && !fail_pipe[STAGES] && (sum_q < best_met_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (i_start) state_d = RUN;
      RUN:   if (i_start) state_d = RUN;
             else if (hs && i_cand_last) state_d = FLUSH;
      FLUSH: if (i_start) state_d = RUN;
             else if (flush_q == 2'd2) state_d = DONE;
      DONE:  state_d = i_start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      flush_q      <= '0;
      cnt_q        <= '0;
      vld_pipe     <= '0;
      started_q    <= 1'b0;
      best_met_q   <= MET_MAX;
      best_valid_q <= 1'b0;
      best_idx_q   <= '0;
      best_cand_q  <= '0;
      ovf_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      flush_q <= (state_q == FLUSH) ? flush_q + 2'd1 : 2'd0;
      if (i_start) begin
        cnt_q        <= '0;
        vld_pipe     <= '0;
        started_q    <= 1'b1;
        best_met_q   <= MET_MAX;
        best_valid_q <= 1'b0;
        best_idx_q   <= '0;
        best_cand_q  <= '0;
        ovf_q        <= 1'b0;
      end else begin
        vld_pipe <= {vld_pipe[STAGES-1:1], score};
        if (hs && !cnt_full) cnt_q <= cnt_q + (CIDX_W+1)'(1);
        if (hs && cnt_full)  ovf_q <= 1'b1;
        if (upd) begin
          best_met_q   <= sum_q;
          best_idx_q   <= idx_pipe[STAGES];
          best_cand_q  <= cand_pipe[STAGES];
          best_valid_q <= 1'b1;
        end
      end
    end
  end

  // Data path carries no reset; vld_pipe alone qualifies it.
  always_ff @(posedge i_clk) begin
    cand_pipe[1] <= cand_in;
    idx_pipe[1]  <= cnt_q[CIDX_W-1:0];
    fail_pipe[1] <= fail_in;
    for (int s = 2; s <= STAGES; s++) begin
      cand_pipe[s] <= cand_pipe[s-1];
      idx_pipe[s]  <= idx_pipe[s-1];
      fail_pipe[s] <= fail_pipe[s-1];
    end
    llr_q <= {i_llr5, i_llr4, i_llr3, i_llr2, i_llr1, i_llr0};
    sum_q <= sum_s2;
  end

  llr_abs_sum u_abs_sum (
    .cand (cand_pipe[2]),
    .llr  (llr_q),
    .sum  (sum_s2)
  );

  assign o_llr_pos0    = i_cand_pos0;
  assign o_llr_pos1    = i_cand_pos1;
  assign o_llr_pos2    = i_cand_pos2;
  assign o_llr_pos3    = i_cand_pos3;
  assign o_llr_pos4    = i_cand_pos4;
  assign o_llr_pos5    = i_cand_pos5;
  assign o_cand_ready  = (state_q == RUN);
  assign o_done        = (state_q == DONE);
  assign o_best_valid  = best_valid_q;
  assign o_best_idx    = best_idx_q;
  assign o_best_metric = started_q ? best_met_q : '0;
  assign o_best_num    = best_cand_q.num;
  assign o_best_pos0   = best_cand_q.pos[0];
  assign o_best_pos1   = best_cand_q.pos[1];
  assign o_best_pos2   = best_cand_q.pos[2];
  assign o_best_pos3   = best_cand_q.pos[3];
  assign o_best_pos4   = best_cand_q.pos[4];
  assign o_best_pos5   = best_cand_q.pos[5];
  assign o_overflow    = ovf_q;
endmodule

// File: tb/tb_flip_metric_sel.sv
// Directed, table-driven bench for flip_metric_sel with a few hand sequences.
module tb_flip_metric_sel;
  typedef int a6_t[6];
  typedef struct { int num; a6_t pos; a6_t llr; bit fail; } cand_rec_t;
  typedef struct {
    int first; int n; bit b2b;
    bit exp_valid; int exp_idx; int exp_metric; int exp_num; bit exp_ovf;
  } batch_t;

  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;

  logic       start = 0, cand_valid = 0, cand_last = 0;
  logic [2:0] cand_num = 0;
  logic [9:0] cp0 = 0, cp1 = 0, cp2 = 0, cp3 = 0, cp4 = 0, cp5 = 0;
  logic [6:0] l0 = 0, l1 = 0, l2 = 0, l3 = 0, l4 = 0, l5 = 0;
  logic [9:0] lp0, lp1, lp2, lp3, lp4, lp5;
  logic [9:0] bp0, bp1, bp2, bp3, bp4, bp5;
  logic       cand_ready, done, best_valid, overflow;
  logic [3:0] best_idx;
  logic [8:0] best_metric;
  logic [2:0] best_num;
`ifdef FLIP_METRIC_FAIL_EN
  logic       cand_fail = 0;
`endif

  flip_metric_sel dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .i_cand_valid(cand_valid), .o_cand_ready(cand_ready), .i_cand_last(cand_last),
    .i_cand_num(cand_num),
    .i_cand_pos0(cp0), .i_cand_pos1(cp1), .i_cand_pos2(cp2),
    .i_cand_pos3(cp3), .i_cand_pos4(cp4), .i_cand_pos5(cp5),
    .o_llr_pos0(lp0), .o_llr_pos1(lp1), .o_llr_pos2(lp2),
    .o_llr_pos3(lp3), .o_llr_pos4(lp4), .o_llr_pos5(lp5),
    .i_llr0(l0), .i_llr1(l1), .i_llr2(l2), .i_llr3(l3), .i_llr4(l4), .i_llr5(l5),
    .o_done(done), .o_best_valid(best_valid), .o_best_idx(best_idx),
    .o_best_metric(best_metric), .o_best_num(best_num),
    .o_best_pos0(bp0), .o_best_pos1(bp1), .o_best_pos2(bp2),
    .o_best_pos3(bp3), .o_best_pos4(bp4), .o_best_pos5(bp5),
    .o_overflow(overflow)
`ifdef FLIP_METRIC_FAIL_EN
    , .i_cand_fail(cand_fail)
`endif
  );

  int checks = 0, failures = 0;
  cand_rec_t cands[$];
  batch_t    batches[$];
  bit        have_prev = 0;
  int        prev_metric = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic void add_c(input int num, input a6_t p, input a6_t l, input bit f = 0);
    cand_rec_t c;
    c.num = num; c.pos = p; c.llr = l; c.fail = f;
    cands.push_back(c);
  endfunction

  function automatic void add_b(input int first, input int n, input bit b2b, input bit v,
                                input int idx, input int met, input int num, input bit ovf);
    batch_t b;
    b.first = first; b.n = n; b.b2b = b2b; b.exp_valid = v; b.exp_idx = idx;
    b.exp_metric = met; b.exp_num = num; b.exp_ovf = ovf;
    batches.push_back(b);
  endfunction

  function automatic int bpos(input int k);
    case (k)
      0: return int'(bp0); 1: return int'(bp1); 2: return int'(bp2);
      3: return int'(bp3); 4: return int'(bp4); default: return int'(bp5);
    endcase
  endfunction

  task automatic drive_cand(input int c, input bit last);
    cand_valid = 1; cand_last = last; cand_num = 3'(cands[c].num);
    cp0 = 10'(cands[c].pos[0]); cp1 = 10'(cands[c].pos[1]); cp2 = 10'(cands[c].pos[2]);
    cp3 = 10'(cands[c].pos[3]); cp4 = 10'(cands[c].pos[4]); cp5 = 10'(cands[c].pos[5]);
`ifdef FLIP_METRIC_FAIL_EN
    cand_fail = cands[c].fail;
`endif
  endtask

  task automatic idle_cand();
    cand_valid = 0; cand_last = 0;
  endtask

  task automatic set_llr(input int c);
    if (c < 0) begin
      l0 = 0; l1 = 0; l2 = 0; l3 = 0; l4 = 0; l5 = 0;
    end else begin
      l0 = 7'(cands[c].llr[0]); l1 = 7'(cands[c].llr[1]); l2 = 7'(cands[c].llr[2]);
      l3 = 7'(cands[c].llr[3]); l4 = 7'(cands[c].llr[4]); l5 = 7'(cands[c].llr[5]);
    end
  endtask

  // Opens a batch, streams its candidates, feeds LLRs one cycle behind each
  // address, then waits for o_done and checks the result.
  task automatic run_batch(input int bi, input batch_t b);
    int lat; bit seen; int w;
    if (!b.b2b) begin
      @(negedge clk);
      chk($sformatf("b%0d_done_pulse", bi), done, 0);
      if (have_prev) chk($sformatf("b%0d_hold_metric", bi), best_metric, prev_metric);
    end
    start = 1; idle_cand(); set_llr(-1);
    @(negedge clk);
    start = 0;
    chk($sformatf("b%0d_ready_run", bi), cand_ready, 1);
    for (int c = 0; c <= b.n; c++) begin
      if (c > 0) @(negedge clk);
      if (c == b.n) chk($sformatf("b%0d_ready_flush", bi), cand_ready, 0);
      if (c < b.n) drive_cand(b.first + c, c == b.n - 1);
      else idle_cand();
      set_llr(c > 0 ? b.first + c - 1 : -1);
    end
    lat = 1; seen = 0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      set_llr(-1);
      lat++;
      seen = done;
    end
    chk($sformatf("b%0d_done_lat", bi), seen ? lat : -1, 4);
    chk($sformatf("b%0d_valid", bi), best_valid, b.exp_valid);
    chk($sformatf("b%0d_metric", bi), best_metric, b.exp_metric);
    chk($sformatf("b%0d_idx", bi), best_idx, b.exp_idx);
    chk($sformatf("b%0d_num", bi), best_num, b.exp_num);
    chk($sformatf("b%0d_ovf", bi), overflow, b.exp_ovf);
    if (b.exp_valid) begin
      w = b.first + b.exp_idx;
      for (int k = 0; k < 6; k++)
        chk($sformatf("b%0d_pos%0d", bi, k), bpos(k), cands[w].pos[k]);
    end
    have_prev = 1; prev_metric = b.exp_metric;
  endtask

  initial begin
    int f, a0, a1, seen;

    // B0: 10+4+64 = 78
    f = cands.size();
    add_c(3, '{5, 9, 700, 0, 0, 0}, '{-10, 4, -64, 0, 0, 0});
    add_b(f, 1, 0, 1, 0, 78, 3, 0);
    // B1 (issued in the o_done cycle): 50/20/20/90, tie keeps idx 1
    f = cands.size();
    add_c(1, '{11, 0, 0, 0, 0, 0}, '{50, 0, 0, 0, 0, 0});
    add_c(1, '{12, 0, 0, 0, 0, 0}, '{-20, 0, 0, 0, 0, 0});
    add_c(2, '{13, 14, 0, 0, 0, 0}, '{10, -10, 0, 0, 0, 0});
    add_c(2, '{15, 16, 0, 0, 0, 0}, '{45, -45, 0, 0, 0, 0});
    add_b(f, 4, 1, 1, 1, 20, 1, 0);
    // B2: num=0 candidate (junk LLRs masked) beats metric-30 ones
    f = cands.size();
    add_c(1, '{20, 0, 0, 0, 0, 0}, '{-30, 0, 0, 0, 0, 0});
    add_c(0, '{21, 22, 0, 0, 0, 0}, '{63, 63, 63, 63, 63, 63});
    add_c(2, '{23, 24, 0, 0, 0, 0}, '{15, 15, 0, 0, 0, 0});
    add_b(f, 3, 0, 1, 1, 0, 0, 0);
    // B3: lane 2 at position 1023 is ignored -> 7+8
    f = cands.size();
    add_c(3, '{3, 4, 1023, 0, 0, 0}, '{7, -8, 50, 0, 0, 0});
    add_b(f, 1, 0, 1, 0, 15, 3, 0);
    // B4: num=7 acts as 6 -> 1+..+6
    f = cands.size();
    add_c(7, '{1, 2, 3, 4, 5, 6}, '{-1, -2, -3, -4, -5, -6});
    add_b(f, 1, 0, 1, 0, 21, 6, 0);
    // B5: 16 scored (min 20 at idx 7), 17th metric 0 is not scored
    f = cands.size();
    for (int i = 0; i < 16; i++)
      add_c(1, '{i, 0, 0, 0, 0, 0}, '{20 + 2 * (i > 7 ? i - 7 : 7 - i), 0, 0, 0, 0, 0});
    add_c(0, '{100, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0});
    add_b(f, 17, 0, 1, 7, 20, 1, 1);
`ifdef FLIP_METRIC_FAIL_EN
    f = cands.size();
    add_c(1, '{30, 0, 0, 0, 0, 0}, '{10, 0, 0, 0, 0, 0}, 1);
    add_c(1, '{31, 0, 0, 0, 0, 0}, '{20, 0, 0, 0, 0, 0}, 1);
    add_c(1, '{32, 0, 0, 0, 0, 0}, '{30, 0, 0, 0, 0, 0}, 1);
    add_b(f, 3, 0, 0, 0, 511, 0, 0);
    f = cands.size();
    add_c(1, '{33, 0, 0, 0, 0, 0}, '{5, 0, 0, 0, 0, 0}, 1);
    add_c(1, '{34, 0, 0, 0, 0, 0}, '{-10, 0, 0, 0, 0, 0}, 0);
    add_c(1, '{35, 0, 0, 0, 0, 0}, '{1, 0, 0, 0, 0, 0}, 1);
    add_b(f, 3, 0, 1, 1, 10, 1, 0);
`endif
    // abort candidates (metrics 5, 6) followed by the real batch (40)
    a0 = cands.size();
    add_c(1, '{40, 0, 0, 0, 0, 0}, '{5, 0, 0, 0, 0, 0});
    a1 = cands.size();
    add_c(1, '{41, 0, 0, 0, 0, 0}, '{-6, 0, 0, 0, 0, 0});
    f = cands.size();
    add_c(2, '{42, 43, 0, 0, 0, 0}, '{20, -20, 0, 0, 0, 0});

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", cand_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", best_valid, 0);
    chk("rst_metric", best_metric, 0);
    chk("rst_idx", best_idx, 0);
    chk("rst_ovf", overflow, 0);
    rst_n = 1;
    @(negedge clk);
    chk("idle_ready", cand_ready, 0);

    for (int bi = 0; bi < batches.size(); bi++) run_batch(bi, batches[bi]);

    // abort in RUN after two candidates; restart goes out in the next cycle
    @(negedge clk);
    start = 1; @(negedge clk); start = 0;
    drive_cand(a0, 0); set_llr(-1);
    @(negedge clk); drive_cand(a1, 0); set_llr(a0);
    @(negedge clk); idle_cand(); set_llr(a1);
    begin
      batch_t b;
      b.first = f; b.n = 1; b.b2b = 1; b.exp_valid = 1; b.exp_idx = 0;
      b.exp_metric = 40; b.exp_num = 2; b.exp_ovf = 0;
      run_batch(90, b);
    end

    // sync reset in FLUSH
    @(negedge clk);
    start = 1; @(negedge clk); start = 0;
    drive_cand(0, 1); set_llr(-1);
    #1 chk("llr_pos2", lp2, 700);
    @(negedge clk); idle_cand(); set_llr(0);
    chk("fl_ready", cand_ready, 0);
    @(negedge clk); rst_n = 0; set_llr(-1);
    @(negedge clk);
    chk("fl_rst_done", done, 0);
    chk("fl_rst_ready", cand_ready, 0);
    chk("fl_rst_valid", best_valid, 0);
    chk("fl_rst_metric", best_metric, 0);
    chk("fl_rst_num", best_num, 0);
    chk("fl_rst_pos0", bp0, 0);
    chk("fl_rst_ovf", overflow, 0);
    rst_n = 1;
    seen = 0;
    repeat (6) begin @(negedge clk); if (done) seen = 1; end
    chk("fl_no_done", seen, 0);
    chk("fl_idle_ready", cand_ready, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
